// File: rtl/error_metrics_8b.sv
// Streaming accuracy accumulator for 8-bit approximate adders.
// Two-stage pipeline: per-sample error, then run-wide accumulation.
module error_metrics_8b #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [8:0]         s_approx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W+8:0]   ed_sum,
  output logic [CNT_W+9:0]   ed_sgn_sum,
  output logic [8:0]         ed_max
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [9:0] diff;
    logic [8:0] mag;
    logic       nz;
  } s1_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             s1_valid;
  s1_t              s1;
  s1_t              s1_d;

  logic       start_ok;
  logic       zero_req;
  logic       accept;
  logic       last;
  logic [8:0] exact;
  logic [9:0] diff;
  logic [9:0] neg;

  assign start_ok = start &&
                    (state == IDLE || state == DONE);
  assign zero_req = (num_samples == '0);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = acc_cnt + CNT_W'(1);
  assign last     = accept && (cnt_inc == target);

  assign exact = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, s_approx} - {1'b0, exact};
  assign neg   = -diff;

  always_comb begin
    s1_d.diff = diff;
    s1_d.mag  = diff[9] ? neg[8:0] : diff[8:0];
    s1_d.nz   = (diff != '0);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) nxt = zero_req ? DONE : RUN;
      end
      RUN: begin
        if (last) nxt = DRAIN;
      end
      DRAIN: begin
        // stage 1 empty means stage 2 has consumed the final sample
        if (!s1_valid) nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == RUN);
      busy     <= (nxt == RUN) || (nxt == DRAIN);
      // an empty run shows done one cycle after start
      done     <= (nxt == DONE) &&
                  !(start_ok && zero_req);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target  <= '0;
      acc_cnt <= '0;
    end else if (start_ok) begin
      target  <= num_samples;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1 <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      ed_sum     <= '0;
      ed_sgn_sum <= '0;
      ed_max     <= '0;
    end else if (start_ok) begin
      err_count  <= '0;
      ed_sum     <= '0;
      ed_sgn_sum <= '0;
      ed_max     <= '0;
    end else if (s1_valid) begin
      err_count  <= err_count + CNT_W'(s1.nz);
      ed_sum     <= ed_sum + (CNT_W+9)'(s1.mag);
      ed_sgn_sum <= ed_sgn_sum +
                    {{CNT_W{s1.diff[9]}}, s1.diff};
      if (s1.mag > ed_max) ed_max <= s1.mag;
    end
  end

endmodule

// File: doc/error_metrics_8b.md
# error_metrics_8b

Streaming error-metric accumulator that sits directly downstream of the 8-bit approximate ripple-carry adders. For each accepted sample it recomputes the exact 9-bit sum of the operands and compares it against the approximate sum produced by the adder under test. Over a programmed number of samples it accumulates the error count, total error distance, signed error sum and maximum error distance. These figures are the accuracy metrics reported for each approximate adder configuration.

## Interface
- CNT_W, 16, width of the sample counter and of `num_samples` / `err_count`
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- start  in  1  pulse; begins a measurement run; sampled only in IDLE or DONE
- num_samples  in  CNT_W  samples per run; captured on accepted `start`
- in_valid  in  1  a, b and s_approx carry a sample
- in_ready  out  1  block accepts a sample this cycle
- a, b  in  8  operands applied to the adder under test
- s_approx  in  9  approximate sum from the adder under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; results valid and held
- err_count  out  CNT_W  samples with s_approx != a+b
- ed_sum  out  CNT_W+9  sum of |s_approx − (a+b)|
- ed_sgn_sum  out  CNT_W+10  signed sum of (s_approx − (a+b)), two's complement
- ed_max  out  9  maximum |s_approx − (a+b)|

## Operation
- States:
  - IDLE: reset state.
  - RUN: accepting samples.
  - DRAIN: 2-stage pipeline emptying.
  - DONE: results held.
- IDLE/DONE + start:
  - Capture `num_samples`.
  - Clear all four accumulators and the accepted counter.
  - Go to RUN.
  - If `num_samples` == 0, go directly to DONE instead, with all results zero.
- Accept: `in_valid && in_ready`.
- `in_ready` = 1 only in RUN.
  - It drops the cycle after the accepted counter reaches `num_samples`.
- RUN → DRAIN on the edge that accepts sample number `num_samples`.
- DRAIN → DONE when pipeline stage 2 has retired the last sample.
- Stage 1 (registered):
  - exact = {1'b0,a} + {1'b0,b}, 9 bits, with no overflow possible (max 510).
  - diff = s_approx − exact, 10-bit signed.
  - abs = |diff|, 9 bits, max 511.
  - nz = (diff != 0).
- Stage 2 (registered):
  - err_count += nz.
  - ed_sum += abs.
  - ed_sgn_sum += sign-extended diff.
  - ed_max = max(ed_max, abs).
- Accumulator widths are sized so nothing overflows for any `num_samples` ≤ 2^CNT_W − 1, so no saturation logic is required.
- `start` in RUN or DRAIN is ignored.
- `start` in DONE restarts a run and clears results on the same edge.
- `in_valid` outside RUN is ignored, and samples offered outside RUN are never counted.
- Reset mid-run (rst_n low) immediately:
  - state → IDLE.
  - busy = done = in_ready = 0.
  - all accumulators, counters and pipeline valid flags → 0.
  - A partial run is discarded.

## Timing
- Reset values:
  - in_ready = 0, busy = 0, done = 0.
  - err_count = 0, ed_sum = 0, ed_sgn_sum = 0, ed_max = 0.
- Edge numbering: `start` accepted at edge T.
  - busy = 1 and in_ready = 1 from T.
  - The first sample can be accepted at edge T+1.
- Latency from the final accept at edge E:
  - stage 1 holds the sample after E.
  - accumulators update at E+1.
  - done = 1 and busy = 0 from edge E+2.
  - in_ready = 0 from E.
- Throughput: one sample per cycle with `in_valid` held high.
  - Gaps in `in_valid` stall counting only; the pipeline still drains correctly.
- `num_samples` == 0: done = 1 from edge T+1; busy never asserts.
- Outputs are registered and stable while `done` = 1, until the next accepted `start` or reset.

## Test plan
- Exact adder, 4 samples with `s_approx` = a+b (3+4=7, 255+255=510, 0+0=0, 128+127=255):
  - done 2 cycles after the 4th accept.
  - err_count = 0, ed_sum = 0, ed_sgn_sum = 0, ed_max = 0.
- 3 samples:
  - (200,100,s=290): diff −10.
  - (15,1,s=15): diff −1.
  - (5,5,s=14): diff +4.
  - Expected: err_count = 3, ed_sum = 15, ed_sgn_sum = −7, ed_max = 10.
- `num_samples` = 0:
  - done at T+1, all results 0.
  - in_ready never asserted.
  - `in_valid` pulses during this time are ignored.
- Back-pressure and gaps, `num_samples` = 5:
  - `in_valid` toggles 1,0,1,1,0,1,1 with `s_approx` = a+b+1.
  - Exactly 5 accepts; err_count = 5, ed_sum = 5, ed_max = 1.
  - in_ready low after the 5th accept.
- Reset asserted during RUN after 2 accepts:
  - All outputs 0 asynchronously; state IDLE.
  - A subsequent run of 1 sample with diff +3 gives ed_sum = 3, with no leftover from the aborted run.
- `start` pulsed during RUN is ignored, and the run completes with the original `num_samples`.
  - `start` in DONE clears the results and restarts.
  - Random 1000-sample run compared against a bench model.
